// File: rtl/alu_exec_pkg.sv
// Shared definitions for the ALU execute stage: internal operation codes,
// instruction opcode constants and flag bit positions.
package alu_exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_MUL   = 4'h4,
        OP_DIV   = 4'h5,
        OP_SLL   = 4'h6,
        OP_SRL   = 4'h7,
        OP_SRA   = 4'h8,
        OP_ROL   = 4'h9,
        OP_ROR   = 4'hA,
        OP_PASSB = 4'hB,
        OP_NOP   = 4'hF
    } alu_op_t;

    localparam logic [3:0] OPC_RTYPE = 4'b0000;
    localparam logic [3:0] OPC_BEQ   = 4'b0100;
    localparam logic [3:0] OPC_BLT   = 4'b0101;
    localparam logic [3:0] OPC_BGT   = 4'b0110;
    localparam logic [3:0] OPC_MOV   = 4'b0111;
    localparam logic [3:0] OPC_ANDI  = 4'b1000;
    localparam logic [3:0] OPC_ORI   = 4'b1001;
    localparam logic [3:0] OPC_LW    = 4'b1010;
    localparam logic [3:0] OPC_SW    = 4'b1011;
    localparam logic [3:0] OPC_LB    = 4'b1100;
    localparam logic [3:0] OPC_SB    = 4'b1101;

    localparam int FLAG_Z = 0;
    localparam int FLAG_V = 1;

endpackage

// File: rtl/alu_exec_unit_decode.sv
// Instruction decode: maps the opcode (and func field for R-type) onto the
// internal ALU operation.
module alu_decode
    import alu_exec_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] func,
    output logic [3:0] alu_op
);

    always_comb begin
        alu_op = OP_NOP;
        case (opcode)
            OPC_RTYPE:                      alu_op = func;
            OPC_ANDI:                       alu_op = OP_AND;
            OPC_ORI:                        alu_op = OP_OR;
            OPC_LW, OPC_SW, OPC_LB, OPC_SB: alu_op = OP_ADD;
            OPC_BEQ, OPC_BLT, OPC_BGT:      alu_op = OP_SUB;
            OPC_MOV:                        alu_op = OP_PASSB;
            default:                        alu_op = OP_NOP;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: combinational decode and pc+2, single-cycle datapath and
// registered result/flag outputs with clock enable.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLOCK,
    input  logic             CLEAR,
    input  logic             en,
    input  logic [3:0]       opcode,
    input  logic [3:0]       func,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus2,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [1:0]       flags
);

    localparam int SHW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]   sum, diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   div_b;
    logic [WIDTH-1:0]   quot, rem;
    logic [SHW-1:0]     amt;
    logic [2*WIDTH-1:0] rol_wide, ror_wide;
    logic [WIDTH-1:0]   lo_next, hi_next;
    logic               v_next;
    logic [WIDTH-1:0]   lo_reg, hi_reg;
    logic [1:0]         flags_reg;

    alu_decode u_decode (
        .opcode (opcode),
        .func   (func),
        .alu_op (alu_op)
    );

    assign pc_plus2 = pc + WIDTH'(2);

    assign sum  = src1 + src2;
    assign diff = src1 - src2;
    assign prod = $signed(src1) * $signed(src2);
    assign amt  = src2[SHW-1:0];

    // Divide by a harmless value in the two special cases so the divider never
    // sees 0 or MIN/-1; their results are overridden below anyway.
    assign div_b = ((src2 == '0) || (src1 == MIN_NEG && src2 == '1)) ? WIDTH'(1) : src2;
    assign quot  = WIDTH'($signed(src1) / $signed(div_b));
    assign rem   = WIDTH'($signed(src1) % $signed(div_b));

    assign rol_wide = {src1, src1} << amt;
    assign ror_wide = {src1, src1} >> amt;

    always_comb begin
        lo_next = '0;
        hi_next = '0;
        v_next  = 1'b0;
        case (alu_op)
            OP_ADD: begin
                lo_next = sum;
                v_next  = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_SUB: begin
                lo_next = diff;
                v_next  = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]);
            end
            OP_AND:   lo_next = src1 & src2;
            OP_OR:    lo_next = src1 | src2;
            OP_PASSB: lo_next = src2;
            OP_MUL: begin
                lo_next = prod[WIDTH-1:0];
                hi_next = prod[2*WIDTH-1:WIDTH];
                // Fits in signed WIDTH bits only if the upper half is a sign extension
                v_next  = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
            end
            OP_DIV: begin
                if (src2 == '0) begin
                    lo_next = '1;
                    hi_next = src1;
                    v_next  = 1'b1;
                end else if (src1 == MIN_NEG && src2 == '1) begin
                    lo_next = MIN_NEG;
                    v_next  = 1'b1;
                end else begin
                    lo_next = quot;
                    hi_next = rem;
                end
            end
            OP_SLL: lo_next = src1 << amt;
            OP_SRL: lo_next = src1 >> amt;
            OP_SRA: lo_next = WIDTH'($signed(src1) >>> amt);
            OP_ROL: lo_next = rol_wide[2*WIDTH-1:WIDTH];
            OP_ROR: lo_next = ror_wide[WIDTH-1:0];
            default: begin
                lo_next = '0;
                hi_next = '0;
                v_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (CLEAR) begin
            lo_reg    <= '0;
            hi_reg    <= '0;
            flags_reg <= 2'b00;
        end else if (en) begin
            lo_reg            <= lo_next;
            hi_reg            <= hi_next;
            flags_reg[FLAG_Z] <= (lo_next == '0);
            flags_reg[FLAG_V] <= v_next;
        end
    end

    assign result_lo = lo_reg;
    assign result_hi = hi_reg;
    assign flags     = flags_reg;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: one task per feature,
// hand-computed expected values, one line per transaction.
module tb_alu_exec_unit;

    logic        CLOCK = 1'b0;
    logic        CLEAR = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic [3:0]  func = 4'h0;
    logic [15:0] src1 = 16'h0;
    logic [15:0] src2 = 16'h0;
    logic [15:0] pc = 16'h0;
    logic [15:0] pc_plus2;
    logic [3:0]  alu_op;
    logic [15:0] result_lo;
    logic [15:0] result_hi;
    logic [1:0]  flags;

    int tests = 0;
    int fails = 0;

    alu_exec_unit #(.WIDTH(16)) dut (
        .CLOCK     (CLOCK),
        .CLEAR     (CLEAR),
        .en        (en),
        .opcode    (opcode),
        .func      (func),
        .src1      (src1),
        .src2      (src2),
        .pc        (pc),
        .pc_plus2  (pc_plus2),
        .alu_op    (alu_op),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .flags     (flags)
    );

    always #5 CLOCK = ~CLOCK;

    // Drive one operation, let one rising edge sample it, observe 1 time unit later.
    task automatic do_op(input logic [3:0] opc, input logic [3:0] fn,
                         input logic [15:0] a, input logic [15:0] b);
        opcode = opc;
        func   = fn;
        src1   = a;
        src2   = b;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic test_reset;
        CLEAR = 1'b1;
        en    = 1'b0;
        @(posedge CLOCK);
        #1;
        CLEAR = 1'b0;
        tests++;
        if ({result_lo, result_hi, flags} !== {16'h0, 16'h0, 2'b00}) begin
            fails++;
            $display("FAIL reset: lo=%h hi=%h flags=%b expected 0000 0000 00", result_lo, result_hi, flags);
        end else
            $display("[TB] reset: lo=%h hi=%h flags=%b", result_lo, result_hi, flags);
    endtask

    task automatic test_addsub_logic;
        logic [3:0]  fn [6]  = '{4'h0, 4'h1, 4'h1, 4'h2, 4'h3, 4'hB};
        logic [15:0] a  [6]  = '{16'h7FFF, 16'h0000, 16'h8000, 16'hF0F0, 16'hF0F0, 16'h1234};
        logic [15:0] b  [6]  = '{16'h0001, 16'h0001, 16'h0001, 16'h0FF0, 16'h0F0F, 16'h0000};
        logic [15:0] elo[6]  = '{16'h8000, 16'hFFFF, 16'h7FFF, 16'h00F0, 16'hFFFF, 16'h0000};
        logic [1:0]  efl[6]  = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            do_op(4'h0, fn[i], a[i], b[i]);
            tests++;
            if (result_lo !== elo[i] || result_hi !== 16'h0 || flags !== efl[i]) begin
                fails++;
                $display("FAIL addsub_logic[%0d]: lo=%h hi=%h flags=%b expected lo=%h hi=0000 flags=%b",
                         i, result_lo, result_hi, flags, elo[i], efl[i]);
            end else
                $display("[TB] alu func=%h a=%h b=%h -> lo=%h flags=%b", fn[i], a[i], b[i], result_lo, flags);
        end
    endtask

    task automatic test_mul;
        logic [15:0] a  [3] = '{16'hFFFE, 16'h0100, 16'h00FF};
        logic [15:0] b  [3] = '{16'h0003, 16'h0100, 16'hFF00};
        logic [15:0] elo[3] = '{16'hFFFA, 16'h0000, 16'h0100};
        logic [15:0] ehi[3] = '{16'hFFFF, 16'h0001, 16'hFFFF};
        logic [1:0]  efl[3] = '{2'b00, 2'b11, 2'b10};
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_op(4'h0, 4'h4, a[i], b[i]);
            tests++;
            if (result_lo !== elo[i] || result_hi !== ehi[i] || flags !== efl[i]) begin
                fails++;
                $display("FAIL mul[%0d]: lo=%h hi=%h flags=%b expected lo=%h hi=%h flags=%b",
                         i, result_lo, result_hi, flags, elo[i], ehi[i], efl[i]);
            end else
                $display("[TB] mul a=%h b=%h -> lo=%h hi=%h flags=%b", a[i], b[i], result_lo, result_hi, flags);
        end
    endtask

    task automatic test_div;
        logic [15:0] a  [4] = '{16'hFFF9, 16'hFFF9, 16'h8000, 16'h0007};
        logic [15:0] b  [4] = '{16'h0002, 16'h0000, 16'hFFFF, 16'hFFFE};
        logic [15:0] elo[4] = '{16'hFFFD, 16'hFFFF, 16'h8000, 16'hFFFD};
        logic [15:0] ehi[4] = '{16'hFFFF, 16'hFFF9, 16'h0000, 16'h0001};
        logic [1:0]  efl[4] = '{2'b00, 2'b10, 2'b10, 2'b00};
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_op(4'h0, 4'h5, a[i], b[i]);
            tests++;
            if (result_lo !== elo[i] || result_hi !== ehi[i] || flags !== efl[i]) begin
                fails++;
                $display("FAIL div[%0d]: lo=%h hi=%h flags=%b expected lo=%h hi=%h flags=%b",
                         i, result_lo, result_hi, flags, elo[i], ehi[i], efl[i]);
            end else
                $display("[TB] div a=%h b=%h -> lo=%h hi=%h flags=%b", a[i], b[i], result_lo, result_hi, flags);
        end
    endtask

    task automatic test_shift;
        logic [3:0]  fn [7] = '{4'h8, 4'hA, 4'h6, 4'h7, 4'h9, 4'h6, 4'h8};
        logic [15:0] a  [7] = '{16'h8001, 16'h0001, 16'h0001, 16'h8000, 16'h8001, 16'h1234, 16'h4000};
        logic [15:0] b  [7] = '{16'h0004, 16'h0001, 16'h000F, 16'h001F, 16'h0001, 16'h0010, 16'h0002};
        logic [15:0] elo[7] = '{16'hF800, 16'h8000, 16'h8000, 16'h0001, 16'h0003, 16'h1234, 16'h1000};
        en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            do_op(4'h0, fn[i], a[i], b[i]);
            tests++;
            if (result_lo !== elo[i] || result_hi !== 16'h0 || flags !== 2'b00) begin
                fails++;
                $display("FAIL shift[%0d]: lo=%h hi=%h flags=%b expected lo=%h hi=0000 flags=00",
                         i, result_lo, result_hi, flags, elo[i]);
            end else
                $display("[TB] shift func=%h a=%h b=%h -> lo=%h", fn[i], a[i], b[i], result_lo);
        end
    endtask

    task automatic test_decode;
        logic [3:0] opc [9] = '{4'hC, 4'hE, 4'h8, 4'h9, 4'h5, 4'h7, 4'h1, 4'hA, 4'h3};
        logic [3:0] eop [9] = '{4'h0, 4'hF, 4'h2, 4'h3, 4'h1, 4'hB, 4'hF, 4'h0, 4'hF};
        for (int i = 0; i < 9; i++) begin
            opcode = opc[i];
            func   = 4'h4;
            #1;
            tests++;
            if (alu_op !== eop[i]) begin
                fails++;
                $display("FAIL decode opcode=%h: alu_op=%h expected %h", opc[i], alu_op, eop[i]);
            end else
                $display("[TB] decode opcode=%h -> alu_op=%h", opc[i], alu_op);
        end
        // R-type func 1100 is a NOP encoding too
        opcode = 4'h0;
        func   = 4'hC;
        #1;
        tests++;
        if (alu_op !== 4'hC) begin
            fails++;
            $display("FAIL decode rtype func=c: alu_op=%h expected c", alu_op);
        end
    endtask

    task automatic test_nop;
        en = 1'b1;
        do_op(4'h0, 4'h0, 16'h0005, 16'h0005);
        do_op(4'hE, 4'h0, 16'h1234, 16'h5678);
        tests++;
        if (alu_op !== 4'hF || result_lo !== 16'h0 || result_hi !== 16'h0 || flags !== 2'b01) begin
            fails++;
            $display("FAIL nop: alu_op=%h lo=%h hi=%h flags=%b expected f 0000 0000 01",
                     alu_op, result_lo, result_hi, flags);
        end else
            $display("[TB] nop opcode=e -> lo=%h flags=%b", result_lo, flags);
        do_op(4'h0, 4'hD, 16'hFFFF, 16'hFFFF);
        tests++;
        if (result_lo !== 16'h0 || flags !== 2'b01) begin
            fails++;
            $display("FAIL nop_func: lo=%h flags=%b expected 0000 01", result_lo, flags);
        end
    endtask

    task automatic test_pc;
        logic [15:0] p [3] = '{16'hFFFE, 16'h1234, 16'hFFFF};
        logic [15:0] e [3] = '{16'h0000, 16'h1236, 16'h0001};
        CLEAR = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = p[i];
            #1;
            tests++;
            if (pc_plus2 !== e[i]) begin
                fails++;
                $display("FAIL pc_plus2 pc=%h: got %h expected %h", p[i], pc_plus2, e[i]);
            end else
                $display("[TB] pc=%h -> pc_plus2=%h", p[i], pc_plus2);
        end
        @(posedge CLOCK);
        #1;
        CLEAR = 1'b0;
    endtask

    task automatic test_hold;
        en = 1'b1;
        do_op(4'h0, 4'h4, 16'h0100, 16'h0100);
        en = 1'b0;
        do_op(4'h0, 4'h0, 16'h0001, 16'h0001);
        do_op(4'h0, 4'h1, 16'h0003, 16'h0001);
        tests++;
        if (result_lo !== 16'h0000 || result_hi !== 16'h0001 || flags !== 2'b11) begin
            fails++;
            $display("FAIL hold: lo=%h hi=%h flags=%b expected 0000 0001 11", result_lo, result_hi, flags);
        end else
            $display("[TB] hold en=0 -> lo=%h hi=%h flags=%b", result_lo, result_hi, flags);
    endtask

    task automatic test_clear_priority;
        en = 1'b1;
        do_op(4'h0, 4'h0, 16'h1111, 16'h2222);
        CLEAR = 1'b1;
        do_op(4'h0, 4'h4, 16'hFFFE, 16'h0003);
        tests++;
        if ({result_lo, result_hi, flags} !== {16'h0, 16'h0, 2'b00}) begin
            fails++;
            $display("FAIL clear_priority: lo=%h hi=%h flags=%b expected 0000 0000 00", result_lo, result_hi, flags);
        end else
            $display("[TB] clear+en -> lo=%h hi=%h flags=%b", result_lo, result_hi, flags);
        CLEAR = 1'b0;
        en    = 1'b0;
        do_op(4'h0, 4'h0, 16'h0001, 16'h0001);
        tests++;
        if ({result_lo, result_hi, flags} !== {16'h0, 16'h0, 2'b00}) begin
            fails++;
            $display("FAIL clear_discard: lo=%h hi=%h flags=%b expected 0000 0000 00", result_lo, result_hi, flags);
        end else
            $display("[TB] discarded op -> lo=%h flags=%b", result_lo, flags);
    endtask

    task automatic test_back_to_back;
        en = 1'b1;
        do_op(4'h0, 4'h0, 16'h0002, 16'h0003);
        tests++;
        if (result_lo !== 16'h0005 || flags !== 2'b00) begin
            fails++;
            $display("FAIL b2b_0: lo=%h flags=%b expected 0005 00", result_lo, flags);
        end
        do_op(4'hA, 4'h0, 16'h1000, 16'h0020);
        tests++;
        if (result_lo !== 16'h1020 || flags !== 2'b00) begin
            fails++;
            $display("FAIL b2b_1: lo=%h flags=%b expected 1020 00", result_lo, flags);
        end
        do_op(4'h4, 4'h0, 16'h0033, 16'h0033);
        tests++;
        if (result_lo !== 16'h0000 || flags !== 2'b01) begin
            fails++;
            $display("FAIL b2b_2: lo=%h flags=%b expected 0000 01", result_lo, flags);
        end else
            $display("[TB] back-to-back add/lw/beq done");
    endtask

    initial begin
        #2;
        test_reset;
        test_addsub_logic;
        test_mul;
        test_div;
        test_shift;
        test_decode;
        test_nop;
        test_pc;
        test_hold;
        test_clear_priority;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: WIDTH, 16, datapath width; all arithmetic rules below are stated for WIDTH=16.
REQ-002 Reset is synchronous and active-high on CLEAR; the block has one clock, CLOCK, rising edge.
REQ-003 CLOCK  in  1  system clock.
REQ-004 CLEAR  in  1  synchronous active-high reset.
REQ-005 en  in  1  when high, registered outputs load new results; when low, they hold.
REQ-006 opcode  in  4  instruction bits [15:12].
REQ-007 func  in  4  instruction bits [3:0]; used only when opcode=0000.
REQ-008 src1, src2  in  16  ALU operands A and B.
REQ-009 pc  in  16  current program counter.
REQ-010 pc_plus2  out  16  combinational pc+2.
REQ-011 alu_op  out  4  combinational decoded operation.
REQ-012 result_lo  out  16  registered primary result (register write data / memory address).
REQ-013 result_hi  out  16  registered secondary result (R15 write data).
REQ-014 flags  out  2  registered; bit0 = Z (result_lo==0), bit1 = V (overflow / divide error).

Function
REQ-015 Internal op codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 MUL, 0101 DIV, 0110 SLL, 0111 SRL, 1000 SRA, 1001 ROL, 1010 ROR, 1011 PASSB; 1100-1111 NOP.
REQ-016 Decode, opcode=0000: alu_op=func.
REQ-017 Decode, opcodes 1000 (ANDI): AND; 1001 (ORI): OR.
REQ-018 Decode, opcodes 1010, 1011, 1100, 1101 (load/store address): ADD.
REQ-019 Decode, opcodes 0100, 0101, 0110 (branch compare): SUB.
REQ-020 Decode, opcode 0111 (move): PASSB.
REQ-021 Decode, all other opcodes: NOP (1111).
REQ-022 ADD/SUB: two's complement modulo 2^16; result_hi=0; V = signed overflow.
REQ-023 AND/OR/PASSB: bitwise on A,B (PASSB gives B); result_hi=0; V=0.
REQ-024 MUL: signed 16x16 -> 32-bit product; result_lo=product[15:0], result_hi=product[31:16]; V=1 iff product does not fit signed 16 bits.
REQ-025 DIV: signed, quotient truncated toward zero; result_lo=quotient, result_hi=remainder (sign of A).
REQ-026 DIV, B=0: result_lo=16'hFFFF, result_hi=A, V=1.
REQ-027 DIV, A=16'h8000 and B=16'hFFFF: result_lo=16'h8000, result_hi=0, V=1.
REQ-028 Shifts/rotates use amount B[3:0]: SLL/SRL zero-fill, SRA sign-fill, ROL/ROR rotate within 16 bits; amount 0 returns A; result_hi=0; V=0.
REQ-029 NOP: result_lo=0, result_hi=0, V=0.
REQ-030 Z is computed from result_lo for every op, including NOP (Z=1).
REQ-031 Latency: alu_op and pc_plus2 are combinational.
REQ-032 Latency: result_lo, result_hi and flags appear one CLOCK edge after inputs are sampled with en=1.
REQ-033 pc_plus2 = pc+2 mod 2^16, so 16'hFFFE wraps to 16'h0000.
REQ-034 If CLEAR and en are both high at an edge, CLEAR wins.

Reset
REQ-035 At a rising CLOCK with CLEAR=1: result_lo=0, result_hi=0, flags=2'b00.
REQ-036 Combinational outputs are unaffected by CLEAR.
REQ-037 An operation sampled while CLEAR=1 is discarded, not deferred.

Structure
REQ-038 Shared package alu_exec_pkg holds alu_op enum (REQ-015), opcode constants and flag bit indices.
REQ-039 One sub-module, alu_decode (opcode/func -> alu_op), is instantiated.
REQ-040 Datapath and output registers live in alu_exec_unit; no other hierarchy.

Verification
REQ-041 Reset then opcode=0000 func=0000 A=7FFF B=0001 en=1 -> next edge: lo=8000, hi=0000, flags=10.
REQ-042 func=0100 A=FFFE(-2) B=0003 -> lo=FFFA, hi=FFFF, flags=00; A=0100 B=0100 -> lo=0000, hi=0001, flags=11.
REQ-043 func=0101 A=FFF9(-7) B=0002 -> lo=FFFD, hi=FFFF; B=0000 -> lo=FFFF, hi=A, V=1; A=8000 B=FFFF -> lo=8000, V=1.
REQ-044 func=1000 A=8001 B=0004 -> lo=F800; func=1010 A=0001 B=0001 -> lo=8000; opcode=1100 -> alu_op=0000; opcode=1110 -> alu_op=1111, lo=0000, flags=01.
REQ-045 pc=FFFE -> pc_plus2=0000 same cycle; en=0 holds prior outputs; CLEAR with en=1 -> outputs zero.
